// File: rtl/ttt_auto_player.sv
// rtl/ttt_auto_player.sv - tic-tac-toe computer opponent (win / block / preference move picker)
// Optional feature: define TTT_AUTO_BLOCK_EN to scan opponent lines for a block before the preference pick.
module ttt_auto_player #(
  parameter int THINK_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] my_mark,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic [3:0] move_pos,
  output logic       move_valid,
  input  logic       move_ack,
  output logic       no_move,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, SCAN_WIN, SCAN_BLOCK, PICK, THINK, ISSUE} state_t;

  localparam int CW = (THINK_CYCLES > 1) ? $clog2(THINK_CYCLES) : 1;
  localparam logic [CW-1:0] THINK_LAST = CW'((THINK_CYCLES > 0) ? THINK_CYCLES - 1 : 0);

  state_t          state, state_nx;
  logic [8:0][1:0] snap, snap_nx;
  logic [1:0]      mark, mark_nx;
  logic [2:0]      line, line_nx;
  logic [CW-1:0]   think_cnt, think_cnt_nx;
  logic [3:0]      pos_nx;
  logic            valid_nx, no_move_nx;

  // Cell indices (0..8) of each line, packed as {a, b, c}.
  function automatic logic [11:0] line_cells(input logic [2:0] l);
    case (l)
      3'd0:    return {4'd0, 4'd1, 4'd2};
      3'd1:    return {4'd3, 4'd4, 4'd5};
      3'd2:    return {4'd6, 4'd7, 4'd8};
      3'd3:    return {4'd0, 4'd3, 4'd6};
      3'd4:    return {4'd1, 4'd4, 4'd7};
      3'd5:    return {4'd2, 4'd5, 4'd8};
      3'd6:    return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  // Preference order: centre, corners, then edges.
  function automatic logic [3:0] pref_cell(input int i);
    case (i)
      0:       return 4'd4;
      1:       return 4'd0;
      2:       return 4'd2;
      3:       return 4'd6;
      4:       return 4'd8;
      5:       return 4'd1;
      6:       return 4'd3;
      7:       return 4'd5;
      default: return 4'd7;
    endcase
  endfunction

  logic [3:0] c0, c1, c2, hit_pos, pick_pos, take_pos;
  logic [1:0] v0, v1, v2, target;
  logic       hit, pick_found, take;

  always_comb begin
    {c0, c1, c2} = line_cells(line);
    v0 = snap[c0];
    v1 = snap[c1];
    v2 = snap[c2];
    target = (state == SCAN_BLOCK) ? (mark ^ 2'b11) : mark;
    hit = 1'b0;
    hit_pos = 4'd0;
    if (v0 == 2'b00 && v1 == target && v2 == target) begin
      hit = 1'b1;
      hit_pos = c0;
    end else if (v1 == 2'b00 && v0 == target && v2 == target) begin
      hit = 1'b1;
      hit_pos = c1;
    end else if (v2 == 2'b00 && v0 == target && v1 == target) begin
      hit = 1'b1;
      hit_pos = c2;
    end
    pick_found = 1'b0;
    pick_pos = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (snap[pref_cell(i)] == 2'b00) begin
        pick_found = 1'b1;
        pick_pos = pref_cell(i);
      end
    end
  end

  always_comb begin
    state_nx     = state;
    snap_nx      = snap;
    mark_nx      = mark;
    line_nx      = line;
    think_cnt_nx = think_cnt;
    pos_nx       = move_pos;
    valid_nx     = move_valid;
    no_move_nx   = 1'b0;
    take         = 1'b0;
    take_pos     = hit_pos;
    case (state)
      IDLE: begin
        if (req) begin
          if (my_mark == 2'b00 || my_mark == 2'b11) begin
            no_move_nx = 1'b1;
          end else begin
            snap_nx  = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
            mark_nx  = my_mark;
            line_nx  = 3'd0;
            state_nx = SCAN_WIN;
          end
        end
      end
      SCAN_WIN: begin
        if (hit) begin
          take = 1'b1;
        end else if (line == 3'd7) begin
          line_nx = 3'd0;
`ifdef TTT_AUTO_BLOCK_EN
          state_nx = SCAN_BLOCK;
`else
          state_nx = PICK;
`endif
        end else begin
          line_nx = line + 3'd1;
        end
      end
      SCAN_BLOCK: begin
        if (hit) begin
          take = 1'b1;
        end else if (line == 3'd7) begin
          line_nx  = 3'd0;
          state_nx = PICK;
        end else begin
          line_nx = line + 3'd1;
        end
      end
      PICK: begin
        if (pick_found) begin
          take     = 1'b1;
          take_pos = pick_pos;
        end else begin
          no_move_nx = 1'b1;
          state_nx   = IDLE;
        end
      end
      THINK: begin
        if (think_cnt == THINK_LAST) begin
          state_nx = ISSUE;
          valid_nx = 1'b1;
        end else begin
          think_cnt_nx = think_cnt + CW'(1);
        end
      end
      ISSUE: begin
        if (move_ack) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A chosen cell either waits out the think delay or is presented on the next edge.
    if (take) begin
      pos_nx       = take_pos;
      think_cnt_nx = '0;
      if (THINK_CYCLES == 0) begin
        state_nx = ISSUE;
        valid_nx = 1'b1;
      end else begin
        state_nx = THINK;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      snap       <= '0;
      mark       <= 2'b00;
      line       <= 3'd0;
      think_cnt  <= '0;
      move_pos   <= 4'd0;
      move_valid <= 1'b0;
      no_move    <= 1'b0;
    end else begin
      state      <= state_nx;
      snap       <= snap_nx;
      mark       <= mark_nx;
      line       <= line_nx;
      think_cnt  <= think_cnt_nx;
      move_pos   <= pos_nx;
      move_valid <= valid_nx;
      no_move    <= no_move_nx;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ttt_auto_player.sv
// tb/tb_ttt_auto_player.sv - scoreboard bench for ttt_auto_player against a rule-level move model
module tb_ttt_auto_player;

  localparam int TC = 2;
`ifdef TTT_AUTO_BLOCK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic [1:0] my_mark = 2'b00;
  logic [1:0] pos1 = 0, pos2 = 0, pos3 = 0, pos4 = 0, pos5 = 0, pos6 = 0, pos7 = 0, pos8 = 0, pos9 = 0;
  logic [3:0] move_pos;
  logic       move_valid;
  logic       move_ack = 1'b0;
  logic       no_move;
  logic       busy;

  ttt_auto_player #(.THINK_CYCLES(TC)) dut (
    .clock(clock), .reset(reset), .req(req), .my_mark(my_mark),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
    .move_pos(move_pos), .move_valid(move_valid), .move_ack(move_ack),
    .no_move(no_move), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit is_move;
    int pos;
    int edge_no;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int pref[9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outcome; edge_no holds the latency from the req-sampling edge.
  function automatic exp_t model(logic [1:0] b[9], logic [1:0] m);
    exp_t e;
    int base;
    e.is_move = 1'b0;
    e.pos = 0;
    e.edge_no = 0;
    if (m == 2'b00 || m == 2'b11) return e;
    for (int pass = 0; pass <= (BLK ? 1 : 0); pass++) begin
      logic [1:0] t = (pass == 1) ? (m ^ 2'b11) : m;
      for (int l = 0; l < 8; l++) begin
        int mine = 0, empties = 0, hole = 0;
        for (int c = 0; c < 3; c++) begin
          if (b[lines[l][c]] == t) mine++;
          if (b[lines[l][c]] == 2'b00) begin
            empties++;
            hole = lines[l][c];
          end
        end
        if (mine == 2 && empties == 1) begin
          e.is_move = 1'b1;
          e.pos = hole;
          e.edge_no = 1 + 8 * pass + l + TC;
          return e;
        end
      end
    end
    base = BLK ? 17 : 9;
    for (int i = 0; i < 9; i++) begin
      if (b[pref[i]] == 2'b00) begin
        e.is_move = 1'b1;
        e.pos = pref[i];
        e.edge_no = base + TC;
        return e;
      end
    end
    e.edge_no = base;
    return e;
  endfunction

  task automatic drive_board(logic [1:0] b[9]);
    {pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9} =
      {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7], b[8]};
  endtask

  task automatic rand_board(output logic [1:0] b[9]);
    for (int i = 0; i < 9; i++) begin
      int r = $urandom_range(0, 9);
      b[i] = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
    end
  endtask

  // One turn: request, then service the handshake; hold<0 picks a random ack delay.
  task automatic issue(logic [1:0] b[9], logic [1:0] m, bit pre_ack, bit noise, int hold);
    exp_t e;
    int   t;
    int   h;
    bit   done;
    logic [1:0] nb[9];
    h = (hold < 0) ? $urandom_range(0, 3) : hold;
    @(negedge clock);
    drive_board(b);
    my_mark = m;
    req = 1'b1;
    move_ack = pre_ack;
    @(posedge clock);
    #1;
    e = model(b, m);
    e.edge_no += cyc;
    sbq.push_back(e);
    req = 1'b0;
    t = 0;
    done = 1'b0;
    while (!done && t < 200) begin
      @(negedge clock);
      t++;
      if (noise) begin
        rand_board(nb);
        drive_board(nb);
        my_mark = 2'($urandom_range(0, 3));
        req = busy ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (move_valid) begin
        if (h == 0 || pre_ack) move_ack = 1'b1;
        else h--;
      end
      if (!busy && !move_valid && sbq.size() == 0) done = 1'b1;
    end
    req = 1'b0;
    move_ack = 1'b0;
    check("turn_complete", int'(done), 1);
  endtask

  // Monitor: pops one expectation per presented move or no_move pulse.
  initial begin
    exp_t e;
    bit   prev_valid = 1'b0;
    logic [3:0] prev_pos = 4'd0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (move_valid) begin
          check("pos_range", int'(move_pos <= 4'd8), 1);
          check("busy_in_issue", int'(busy), 1);
          if (prev_valid) check("pos_stable", int'(move_pos), int'(prev_pos));
        end
        if ((move_valid && !prev_valid) || no_move) begin
          if (sbq.size() == 0) begin
            check("unexpected_event", 1, 0);
          end else begin
            e = sbq.pop_front();
            check("event_kind", int'(move_valid), int'(e.is_move));
            if (e.is_move) check("move_pos", int'(move_pos), e.pos);
            check("event_edge", cyc, e.edge_no);
          end
        end
      end
      prev_valid = move_valid;
      prev_pos = move_pos;
    end
  end

  initial begin
    logic [1:0] b[9];
    #1;
    check("rst_move_pos", int'(move_pos), 0);
    check("rst_move_valid", int'(move_valid), 0);
    check("rst_no_move", int'(no_move), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    b = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    issue(b, 2'b01, 1'b0, 1'b0, 2);
    b = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    issue(b, 2'b10, 1'b0, 1'b0, 0);
    b = '{default: 2'b00};
    issue(b, 2'b01, 1'b0, 1'b0, 10);
    b = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    issue(b, 2'b01, 1'b0, 1'b0, 0);
    check("full_board_idle", int'(busy), 0);
    issue(b, 2'b11, 1'b0, 1'b0, 0);
    check("bad_mark_idle", int'(busy), 0);
    b = '{default: 2'b00};
    issue(b, 2'b10, 1'b1, 1'b1, 0);

    // Reset in the middle of a scan: nothing may be presented afterwards.
    b = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00};
    @(negedge clock);
    drive_board(b);
    my_mark = 2'b01;
    req = 1'b1;
    @(posedge clock);
    #1;
    req = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(move_valid), 0);
    sbq.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    check("abort_idle", int'(busy), 0);

    for (int n = 0; n < 150; n++) begin
      logic [1:0] m;
      rand_board(b);
      m = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00)
                                      : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
      issue(b, m, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), -1);
    end

    repeat (3) @(negedge clock);
    check("queue_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
